reg_muxn: RTL and testbench
===========================

REG_MUXN -- requirements
Module: reg_muxn

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width per channel.
REQ-002 SHALL have parameter NCH, default 4: input channel count, legal range 2..16.
REQ-003 SHALL have derived parameter SELW = max(1, ceil(log2(NCH))): select and pointer width.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1: sole clock, rising edge.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port in_data, input, NCH*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 Port in_valid, input, NCH: per-channel data valid.
REQ-009 Port in_ready, output, NCH: per-channel accept; at most one bit high per cycle.
REQ-010 Port sel, input, SELW: channel select in fixed mode.
REQ-011 Port mode, input, 1: 0 = fixed select, 1 = round-robin.
REQ-012 Port out_data, output, WIDTH: registered selected data.
REQ-013 Port out_valid, output, 1: out_data holds an untaken word.
REQ-014 Port out_ready, input, 1: downstream accept.
REQ-015 Port out_sel, output, SELW: source channel of current out_data.
REQ-016 Port sel_err, output, 1: sticky flag, illegal select seen.

Function
REQ-017 Output stage is one register; load_en = !out_valid || out_ready.
REQ-018 Transfer out occurs on a cycle where out_valid && out_ready; transfer in on channel g occurs where in_valid[g] && in_ready[g].
REQ-019 Latency: a word accepted at edge t is on out_data with out_valid=1 from edge t; one-cycle latency, no combinational path from in_data to out_data.
REQ-020 Fixed mode: grant g = sel when sel < NCH; in_ready[g] = load_en; all other in_ready bits 0.
REQ-021 Fixed mode, sel >= NCH: no grant; all in_ready = 0; sel_err set at next edge.
REQ-022 Round-robin mode: g = first channel with in_valid high, scanning ptr, ptr+1, ... NCH-1, 0, ..., ptr-1; in_ready[g] = load_en.
REQ-023 Round-robin pointer ptr advances to (g+1) mod NCH only on a transfer in during round-robin mode; otherwise holds.
REQ-024 Fixed-mode transfers SHALL NOT modify ptr; switching modes takes effect in the same cycle.
REQ-025 On transfer in, out_data <= selected channel data and out_sel <= g; out_valid <= 1.
REQ-026 Out transfer with no in transfer: out_valid <= 0; out_data and out_sel hold.
REQ-027 Simultaneous out transfer and in transfer: new word loads, out_valid stays 1, no bubble (full throughput).
REQ-028 out_valid=1 and out_ready=0: out_data, out_sel, out_valid hold stable; all in_ready = 0.
REQ-029 No valid channel with load_en high: no state change except out_valid clear per REQ-026.
REQ-030 sel_err clears only on reset.

Reset
REQ-031 rst_n low SHALL asynchronously force out_valid=0, out_data=0, out_sel=0, ptr=0, sel_err=0.
REQ-032 During reset, in_ready SHALL be all 0; a word held mid-transfer at reset assertion is discarded.
REQ-033 First grant possible at the first rising edge after rst_n deasserts.

Structure
REQ-034 Package muxn_pkg SHALL hold MODE_FIXED=0, MODE_RR=1 and the SELW computation function.
REQ-035 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs req, ptr; output grant index, grant_valid).
REQ-036 Output register, ptr, sel_err reside in reg_muxn top.

Verification
REQ-037 Fixed mode, WIDTH=8 NCH=4, sel=2, in_data ch2=0xA5, in_valid=4'b0100, out_ready=1 -> next edge out_data=0xA5, out_sel=2, out_valid=1.
REQ-038 RR mode, all in_valid=1, out_ready=1 continuously, from reset -> out_sel sequence 0,1,2,3,0 on consecutive cycles.
REQ-039 RR mode, in_valid=4'b1010, ptr=2 -> grant 3, then 1, then 3; channels 0 and 2 never granted.
REQ-040 Backpressure: out_valid=1, out_ready=0 for 5 cycles with ch1 valid -> out_data stable, in_ready=0; on out_ready=1 ch1 word loads same edge.
REQ-041 NCH=3, fixed mode, sel=3 -> in_ready=0, sel_err=1 next edge, stays 1 after sel=0 until rst_n pulse.
REQ-042 rst_n asserted asynchronously mid-cycle with out_valid=1 -> out_valid, out_data, out_sel, sel_err =0 before next clk edge.

Source files
------------

// File: rtl/muxn_pkg.sv
// Shared constants and helpers for the registered N-channel mux.
// Mode encodings and the select/pointer width calculation.
package muxn_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Select width: ceil(log2(n)), never less than one bit
    function automatic int selw_f(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant finder: first requester at or after ptr.
// Purely combinational; the pointer register lives in the top.
import muxn_pkg::*;

module rr_arbiter #(
    parameter int NCH  = 4,
    parameter int SELW = selw_f(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] grant,
    output logic            grant_valid
);

    // Scan ptr, ptr+1, ... wrapping, and take the first request
    always_comb begin
        int idx;
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int i = 0; i < NCH; i++) begin
            idx = (int'(ptr) + i) % NCH;
            if (!grant_valid && req[idx]) begin
                grant       = SELW'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_muxn.sv
// Registered N-to-1 channel mux with fixed and round-robin select.
// One output register, full throughput, sticky illegal-select flag.
import muxn_pkg::*;

module reg_muxn #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = selw_f(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_sel,
    output logic                 sel_err
);

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  ptr_nxt;
    logic [SELW-1:0]  rr_g;
    logic             rr_gv;
    logic [SELW-1:0]  g;
    logic             gv;
    logic             load_en;
    logic             sel_ok;
    logic             take;
    logic [WIDTH-1:0] d;
    logic [NCH-1:0]   rdy;

    rr_arbiter #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_arb (
        .req         (in_valid),
        .ptr         (ptr),
        .grant       (rr_g),
        .grant_valid (rr_gv)
    );

    assign load_en = !out_valid || out_ready;
    assign sel_ok  = int'(sel) < NCH;

    // Pick the candidate channel for the current mode
    always_comb begin
        g  = '0;
        gv = 1'b0;
        if (mode == MODE_RR) begin
            g  = rr_g;
            gv = rr_gv;
        end else begin
            g  = sel;
            gv = sel_ok;
        end
    end

    // One-hot ready to the granted channel and its data word
    always_comb begin
        rdy = '0;
        d   = '0;
        for (int k = 0; k < NCH; k++) begin
            if (gv && int'(g) == k) begin
                rdy[k] = load_en && rst_n;
                d      = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = rdy;
    assign take     = |(in_valid & rdy);
    assign ptr_nxt  = (int'(g) == NCH - 1) ? '0 : g + SELW'(1);

    // Output register: load on accept, clear valid when drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= d;
            out_sel   <= g;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Round-robin pointer moves past the winner only on RR accepts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (take && mode == MODE_RR) begin
            ptr <= ptr_nxt;
        end
    end

    // Sticky flag for an out-of-range fixed select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else if (mode == MODE_FIXED && !sel_ok) begin
            sel_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_muxn.sv
// Directed bench for reg_muxn: a 4-channel and a 3-channel instance.
// Expected values are hand-computed per step.
module tb_reg_muxn;

    logic        clk;
    logic        rst_n;

    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [1:0]  sel;
    logic        mode;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_sel;
    logic        sel_err;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [1:0]  sel3;
    logic        mode3;
    logic [7:0]  out_data3;
    logic        out_valid3;
    logic        out_ready3;
    logic [1:0]  out_sel3;
    logic        sel_err3;

    int n_cmp = 0;
    int n_err = 0;

    reg_muxn #(.WIDTH(8), .NCH(4)) u4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel),
        .sel_err   (sel_err)
    );

    reg_muxn #(.WIDTH(8), .NCH(3)) u3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .sel       (sel3),
        .mode      (mode3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_sel   (out_sel3),
        .sel_err   (sel_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_data    = {8'h13, 8'hA5, 8'h11, 8'h10};
        in_valid   = 4'b1111;
        sel        = 2'd0;
        mode       = 1'b0;
        out_ready  = 1'b1;
        in_data3   = {8'h33, 8'h32, 8'h31};
        in_valid3  = 3'b000;
        sel3       = 2'd0;
        mode3      = 1'b0;
        out_ready3 = 1'b1;

        // reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_sel", 32'(out_sel), 32'd0);
        chk("rst_sel_err", 32'(sel_err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // fixed mode, sel=2
        sel      = 2'd2;
        in_valid = 4'b0100;
        #1;
        chk("fix_in_ready", 32'(in_ready), 32'b0100);
        tick();
        chk("fix_out_data", 32'(out_data), 32'hA5);
        chk("fix_out_sel", 32'(out_sel), 32'd2);
        chk("fix_out_valid", 32'(out_valid), 32'd1);

        // drain without new input
        in_valid = 4'b0000;
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_data_hold", 32'(out_data), 32'hA5);
        chk("drain_sel_hold", 32'(out_sel), 32'd2);

        // round robin, all valid; ptr still 0 after fixed traffic
        mode     = 1'b1;
        in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        in_valid = 4'b1111;
        #1;
        chk("rr_in_ready0", 32'(in_ready), 32'b0001);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_seq_sel", 32'(out_sel), 32'(i % 4));
            chk("rr_seq_data", 32'(out_data), 32'h10 + 32'(i % 4));
            chk("rr_seq_valid", 32'(out_valid), 32'd1);
        end

        // ptr is 1: grant ch1 alone to move ptr to 2
        in_valid = 4'b0010;
        tick();
        chk("rr_ch1_sel", 32'(out_sel), 32'd1);
        in_valid = 4'b1010;
        #1;
        chk("rr_p2_ready", 32'(in_ready), 32'b1000);
        tick();
        chk("rr_a_sel", 32'(out_sel), 32'd3);
        chk("rr_p0_ready", 32'(in_ready), 32'b0010);
        tick();
        chk("rr_b_sel", 32'(out_sel), 32'd1);
        tick();
        chk("rr_c_sel", 32'(out_sel), 32'd3);
        chk("rr_c_data", 32'(out_data), 32'h13);

        // backpressure with ch1 waiting
        out_ready = 1'b0;
        in_data   = {8'h13, 8'h12, 8'h5A, 8'h10};
        in_valid  = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            tick();
            chk("bp_data", 32'(out_data), 32'h13);
            chk("bp_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_ready", 32'(in_ready), 32'b0010);
        tick();
        chk("bp_rel_data", 32'(out_data), 32'h5A);
        chk("bp_rel_sel", 32'(out_sel), 32'd1);
        out_ready = 1'b0;
        in_valid  = 4'b0000;

        // NCH=3 illegal select
        in_valid3 = 3'b111;
        sel3      = 2'd3;
        #1;
        chk("n3_bad_ready", 32'(in_ready3), 32'h0);
        chk("n3_err_pre", 32'(sel_err3), 32'd0);
        tick();
        chk("n3_err_set", 32'(sel_err3), 32'd1);
        chk("n3_bad_valid", 32'(out_valid3), 32'd0);
        sel3 = 2'd0;
        #1;
        chk("n3_ok_ready", 32'(in_ready3), 32'b001);
        tick();
        chk("n3_err_sticky", 32'(sel_err3), 32'd1);
        chk("n3_ok_data", 32'(out_data3), 32'h31);
        tick();
        chk("n3_err_sticky2", 32'(sel_err3), 32'd1);

        // async reset mid-cycle, main instance holding a word
        mode     = 1'b0;
        sel      = 2'd0;
        in_valid = 4'b1111;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_data", 32'(out_data), 32'h0);
        chk("ar_sel", 32'(out_sel), 32'd0);
        chk("ar_err3", 32'(sel_err3), 32'd0);
        chk("ar_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("post_rst_data", 32'(out_data), 32'h10);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_err3", 32'(sel_err3), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
